// File: rtl/dcm_lock_sequencer.sv
// dcm_lock_sequencer
// Brings up the board DCM and keeps it up. It pulses DCM RST, waits for LOCKED,
// and retries on timeout. Once lock has been stable long enough, it releases the
// downstream resets one stage at a time. Lock loss re-runs the whole sequence.
// The block is clocked from the free-running oscillator, never from a DCM output,
// so it keeps running while the DCM is unlocked.
module dcm_lock_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 16,
    parameter int STAGES        = 2,
    parameter int STAGE_GAP     = 8,
    parameter int MAX_RETRY     = 7
) (
    input  logic              in_clk,
    input  logic              in_reset_n,
    input  logic              in_dcm_locked,
    input  logic              in_restart,
    output logic              out_dcm_reset,
    output logic [STAGES-1:0] out_reset,
    output logic              out_ready,
    output logic              out_fail,
    output logic [3:0]        out_retry_count,
    output logic              out_lock_lost
);

    // The counter must hold the largest interval any state measures.
    localparam int MAX_AB  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAX_CNT = (MAX_AB > STAGES * STAGE_GAP) ? MAX_AB : STAGES * STAGE_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((STAGES - 1) * STAGE_GAP);

    // The retry count saturates at 15, so a limit above 15 means "never fail".
    localparam logic [4:0] RETRY_LIMIT = 5'((MAX_RETRY > 16) ? 16 : MAX_RETRY);

    // FSM encoding kept as plain constants so it matches the legacy netlists.
    localparam logic [2:0] S_RESET_DCM = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             lock_meta;
    logic             lock_s;

    assign cnt_inc = cnt + CNT_W'(1);

    // Two-flop synchronizer for the asynchronous DCM LOCKED output.
    always_ff @(posedge in_clk) begin
        // NOTE: non-blocking assignments let both flops sample old values on the
        // same edge; blocking ones would collapse the chain into a single flop.
        if (!in_reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= in_dcm_locked;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer FSM; every output is a flop written only here.
    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            state           <= S_RESET_DCM;
            cnt             <= '0;
            out_dcm_reset   <= 1'b1;
            out_reset       <= '1;
            out_ready       <= 1'b0;
            out_fail        <= 1'b0;
            out_retry_count <= 4'd0;
            out_lock_lost   <= 1'b0;
        end else begin
            // NOTE: the lock-lost pulse defaults low every cycle, so only the
            // branch that detects the loss has to raise it.
            out_lock_lost <= 1'b0;

            if (in_restart) begin
                state           <= S_RESET_DCM;
                cnt             <= '0;
                out_dcm_reset   <= 1'b1;
                out_reset       <= '1;
                out_ready       <= 1'b0;
                out_fail        <= 1'b0;
                out_retry_count <= 4'd0;
            end else begin
                case (state)
                    S_RESET_DCM: begin
                        if (cnt == RST_LAST) begin
                            state         <= S_WAIT_LOCK;
                            cnt           <= '0;
                            out_dcm_reset <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    S_WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= S_STABLE;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            cnt           <= '0;
                            out_dcm_reset <= 1'b1;
                            if ({1'b0, out_retry_count} >= RETRY_LIMIT) begin
                                state    <= S_FAIL;
                                out_fail <= 1'b1;
                            end else begin
                                state <= S_RESET_DCM;
                                if (out_retry_count != 4'hF) begin
                                    out_retry_count <= out_retry_count + 4'd1;
                                end
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    S_STABLE: begin
                        if (!lock_s) begin
                            // A glitch restarts the lock wait but is not a retry.
                            state <= S_WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            cnt <= '0;
                            if (STAGES == 1) begin
                                state     <= S_RUN;
                                out_reset <= '0;
                                out_ready <= 1'b1;
                            end else begin
                                state        <= S_RELEASE;
                                out_reset[0] <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end

                    S_RELEASE, S_RUN: begin
                        if (!lock_s) begin
                            // Lock loss: every stage reasserts together.
                            state         <= S_RESET_DCM;
                            cnt           <= '0;
                            out_dcm_reset <= 1'b1;
                            out_reset     <= '1;
                            out_ready     <= 1'b0;
                            out_lock_lost <= 1'b1;
                        end else if (state == S_RELEASE) begin
                            for (int k = 1; k < STAGES; k++) begin
                                if (cnt_inc == CNT_W'(k * STAGE_GAP)) begin
                                    out_reset[k] <= 1'b0;
                                end
                            end
                            if (cnt_inc == RELEASE_LAST) begin
                                state     <= S_RUN;
                                cnt       <= '0;
                                out_ready <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end

                    S_FAIL: begin
                        // Parked with the DCM held in reset until restart.
                        out_dcm_reset <= 1'b1;
                        out_reset     <= '1;
                        out_fail      <= 1'b1;
                    end

                    default: begin
                        // NOTE: unused encodings fall back to a fresh DCM reset
                        // instead of locking up the sequencer.
                        state         <= S_RESET_DCM;
                        cnt           <= '0;
                        out_dcm_reset <= 1'b1;
                        out_reset     <= '1;
                        out_ready     <= 1'b0;
                        out_fail      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// tb_dcm_lock_sequencer
// Directed bench. The stimulus thread queues hand-computed output snapshots,
// each tagged with the clock edge after which it must hold. A monitor on the
// falling edge pops and compares them.
// Snapshot layout: {dcm_reset, reset[1:0], ready, fail, retry_count[3:0], lock_lost}.
module tb_dcm_lock_sequencer;

    typedef struct {
        int          at;
        logic [9:0]  v;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       in_reset_n;
    logic       in_dcm_locked;
    logic       in_restart;
    logic       out_dcm_reset;
    logic [1:0] out_reset;
    logic       out_ready;
    logic       out_fail;
    logic [3:0] out_retry_count;
    logic       out_lock_lost;

    int         edge_n = 0;
    int         n_vec  = 0;
    int         n_err  = 0;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [9:0] act;

    int b, c, d, e, f, g;

    dcm_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .STAGES        (2),
        .STAGE_GAP     (4),
        .MAX_RETRY     (2)
    ) dut (
        .in_clk          (clk),
        .in_reset_n      (in_reset_n),
        .in_dcm_locked   (in_dcm_locked),
        .in_restart      (in_restart),
        .out_dcm_reset   (out_dcm_reset),
        .out_reset       (out_reset),
        .out_ready       (out_ready),
        .out_fail        (out_fail),
        .out_retry_count (out_retry_count),
        .out_lock_lost   (out_lock_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [9:0] snap(input logic dr, input logic [1:0] r, input logic rdy,
                                        input logic fl, input logic [3:0] rc, input logic ll);
        return {dr, r, rdy, fl, rc, ll};
    endfunction

    task automatic check(input string name, input int at, input logic [9:0] got, input logic [9:0] want);
        n_vec++;
        if (at != edge_n || got !== want) begin
            n_err++;
            $display("FAIL %s (edge %0d, checked at %0d): got %b expected %b", name, at, edge_n, got, want);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int at, input logic [9:0] v, input string name);
        exp_t x;
        x.at   = at;
        x.v    = v;
        x.name = name;
        sb.push_back(x);
    endtask

    // Monitor: compare every queued snapshot that is due at this edge.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].at <= edge_n) begin
            mon_e = sb.pop_front();
            act   = {out_dcm_reset, out_reset, out_ready, out_fail, out_retry_count, out_lock_lost};
            check(mon_e.name, mon_e.at, act, mon_e.v);
        end
    end

    initial begin
        in_reset_n    = 1'b0;
        in_dcm_locked = 1'b0;
        in_restart    = 1'b0;
        go(3);

        // Reset values, then clean bring-up with lock rising 10 cycles after release.
        b = edge_n;
        expect_at(b,      snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "reset_state");
        in_reset_n = 1'b1;
        expect_at(b + 3,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "dcm_rst_last_high");
        expect_at(b + 4,  snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "dcm_rst_released");
        expect_at(b + 20, snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "bringup_still_held");
        expect_at(b + 21, snap(1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0), "bringup_stage0");
        expect_at(b + 24, snap(1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0), "bringup_gap");
        expect_at(b + 25, snap(1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0), "bringup_ready");
        go(10);
        in_dcm_locked = 1'b1;
        go(17);

        // Lock loss in RUN, then one timeout to bump the retry count.
        c = edge_n;
        in_dcm_locked = 1'b0;
        expect_at(c + 2,  snap(1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0), "run_before_loss");
        expect_at(c + 3,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b1), "lock_lost_pulse");
        expect_at(c + 4,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "lock_lost_one_cycle");
        expect_at(c + 6,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "reissued_pulse_high");
        expect_at(c + 7,  snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "reissued_pulse_end");
        expect_at(c + 38, snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "timeout_not_yet");
        expect_at(c + 39, snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "timeout_retry1");
        expect_at(c + 42, snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "retry1_pulse_high");
        expect_at(c + 43, snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "retry1_pulse_end");
        go(45);

        // Lock glitch four cycles into STABLE: no release, no retry.
        d = edge_n;
        in_dcm_locked = 1'b1;
        expect_at(d + 10, snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "glitch_back_to_wait");
        expect_at(d + 11, snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "glitch_no_early_release");
        expect_at(d + 18, snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "glitch_seven_samples");
        expect_at(d + 19, snap(1'b0, 2'b10, 1'b0, 1'b0, 4'd1, 1'b0), "glitch_stage0");
        expect_at(d + 23, snap(1'b0, 2'b00, 1'b1, 1'b0, 4'd1, 1'b0), "glitch_ready");
        go(7);
        in_dcm_locked = 1'b0;
        go(1);
        in_dcm_locked = 1'b1;
        go(17);

        // Restart on the same cycle the lock loss is seen: restart wins.
        e = edge_n;
        in_dcm_locked = 1'b0;
        expect_at(e + 2,  snap(1'b0, 2'b00, 1'b1, 1'b0, 4'd1, 1'b0), "prio_run");
        expect_at(e + 3,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "prio_restart_wins");
        expect_at(e + 4,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "prio_no_lost_pulse");
        expect_at(e + 6,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "prio_pulse_high");
        expect_at(e + 7,  snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "prio_pulse_end");
        go(2);
        in_restart = 1'b1;
        go(1);
        in_restart = 1'b0;

        // Lock never arrives: retries 0 -> 1 -> 2, then FAIL.
        expect_at(e + 38,  snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "to_wait0");
        expect_at(e + 39,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "to_retry1");
        expect_at(e + 42,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "to_retry1_high");
        expect_at(e + 43,  snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "to_wait1");
        expect_at(e + 74,  snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0), "to_wait1_end");
        expect_at(e + 75,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd2, 1'b0), "to_retry2");
        expect_at(e + 78,  snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd2, 1'b0), "to_retry2_high");
        expect_at(e + 79,  snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd2, 1'b0), "to_wait2");
        expect_at(e + 110, snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd2, 1'b0), "to_wait2_end");
        expect_at(e + 111, snap(1'b1, 2'b11, 1'b0, 1'b1, 4'd2, 1'b0), "to_fail");
        expect_at(e + 130, snap(1'b1, 2'b11, 1'b0, 1'b1, 4'd2, 1'b0), "fail_held");
        go(127);

        // Restart out of FAIL: new 4-cycle DCM reset pulse.
        f = edge_n;
        in_restart = 1'b1;
        expect_at(f + 1, snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "restart_from_fail");
        expect_at(f + 4, snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "restart_pulse_high");
        expect_at(f + 5, snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "restart_pulse_end");
        go(1);
        in_restart = 1'b0;
        go(6);

        // Synchronous reset in the middle of RELEASE.
        g = edge_n;
        in_dcm_locked = 1'b1;
        expect_at(g + 10, snap(1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "mid_rel_stable");
        expect_at(g + 11, snap(1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0), "mid_rel_stage0");
        expect_at(g + 12, snap(1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0), "mid_rel_gap");
        expect_at(g + 13, snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "reset_mid_release");
        expect_at(g + 14, snap(1'b1, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0), "reset_held");
        go(12);
        in_reset_n = 1'b0;
        go(3);

        // Bounded drain; anything left unchecked counts as a miscompare.
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: expected at edge %0d but never checked, wanted %b", mon_e.name, mon_e.at, mon_e.v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcm_lock_sequencer.md
# dcm_lock_sequencer

Power-up and recovery sequencer for the board DCM clock generator. It pulses the DCM reset and waits for lock, retrying on timeout. Once lock is stable, it releases downstream resets in staged order. It monitors for lock loss and re-runs the sequence when lock drops. It runs on the free-running board oscillator (post-IBUFG), never on a DCM output.

## Interface
Parameters:
- RST_CYCLES, 4: width of the out_dcm_reset pulse in in_clk cycles (≥3 required by DCM).
- LOCK_TIMEOUT, 65536: cycles to wait for lock after the DCM reset pulse ends.
- STABLE_CYCLES, 16: consecutive synchronized-lock samples required before any reset release.
- STAGES, 2: number of downstream reset outputs.
- STAGE_GAP, 8: cycles between successive stage releases.
- MAX_RETRY, 7: lock timeouts tolerated before entering FAIL.

Ports:
- in_clk  in  1  free-running oscillator clock; the only clock.
- in_reset_n  in  1  synchronous, active-low reset.
- in_dcm_locked  in  1  DCM LOCKED, asynchronous; 2-flop synchronized internally.
- in_restart  in  1  single-cycle request to re-run the full sequence.
- out_dcm_reset  out  1  DCM RST, active high.
- out_reset  out  STAGES  active-high downstream resets; bit 0 releases first.
- out_ready  out  1  high only in RUN.
- out_fail  out  1  high only in FAIL.
- out_retry_count  out  4  lock-timeout count, saturating at 15.
- out_lock_lost  out  1  one-cycle pulse when lock drops in RUN.

## Operation
- All outputs are registered.
- Reset values (in_reset_n=0 at an edge): state RESET_DCM, counter 0, out_dcm_reset=1, out_reset=all 1, out_ready=0, out_fail=0, out_retry_count=0, out_lock_lost=0, synchronizer flops cleared.
- lock_s is in_dcm_locked delayed by two flops.
- States and transitions:
  - RESET_DCM: out_dcm_reset=1 and out_reset all 1. After RST_CYCLES cycles go to WAIT_LOCK (counter cleared, out_dcm_reset=0).
  - WAIT_LOCK: counter increments each cycle.
    - lock_s=1: go to STABLE, counter cleared.
    - Counter reaches LOCK_TIMEOUT-1 with lock_s=0: if out_retry_count ≥ MAX_RETRY go to FAIL; otherwise increment out_retry_count and go to RESET_DCM.
  - STABLE: counts consecutive lock_s=1 cycles.
    - lock_s=0: return to WAIT_LOCK with the timeout counter cleared; this is not a retry.
    - Count reaches STABLE_CYCLES: go to RELEASE.
  - RELEASE: out_reset[0] clears on entry; out_reset[k] clears k·STAGE_GAP cycles after entry. When the last bit clears, go to RUN and set out_ready=1 on the same edge.
    - lock_s=0 during RELEASE: same handling as lock loss in RUN.
  - RUN: on lock_s=0, on the next edge: out_lock_lost=1 for one cycle, out_reset all 1, out_ready=0, go to RESET_DCM. out_retry_count is unchanged.
  - FAIL: out_dcm_reset=1, out_reset all 1, out_fail=1. Exit only via in_restart or in_reset_n.
- in_restart=1, in any state: next edge goes to RESET_DCM, counter 0, out_retry_count=0, out_reset all 1, out_ready=0, out_fail=0.
- Priority: in_reset_n > in_restart > lock loss > timeout/counter expiry.
- Counter width is sized for max(LOCK_TIMEOUT, STABLE_CYCLES, STAGES·STAGE_GAP). It never wraps; it is cleared on every state change.
- out_reset bits reassert all together, in the same cycle, never staged.

## Timing
- out_dcm_reset is high for exactly RST_CYCLES edges after the first edge sampling in_reset_n=1 (and after each RESET_DCM entry).
- Lock detection latency: in_dcm_locked rising → STABLE entry 3 edges later (2 sync + 1 state).
- STABLE entry → RELEASE entry: STABLE_CYCLES edges.
- RELEASE entry → out_ready high: (STAGES-1)·STAGE_GAP edges.
- Lock loss in RUN: in_dcm_locked falling → out_reset high and out_lock_lost pulse 3 edges later.
- Timeout: WAIT_LOCK entry → RESET_DCM re-entry after LOCK_TIMEOUT edges.
- in_restart → outputs updated on the next edge (1-cycle latency).

## Test plan
Parameters for the bench: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, STAGES=2, STAGE_GAP=4, MAX_RETRY=2.
- **Clean bring-up.** Release reset, raise in_dcm_locked 10 cycles later → out_dcm_reset high for 4 cycles; out_reset[0] clears 11 cycles after lock rises; out_reset[1] and out_ready follow 4 cycles later.
- **Lock glitch in STABLE.** Drop in_dcm_locked for 1 cycle 4 cycles into STABLE → return to WAIT_LOCK; out_reset stays 2'b11; out_retry_count stays 0; release only after 8 fresh stable samples.
- **Timeout to FAIL.** Hold in_dcm_locked=0 → three DCM reset pulses, out_retry_count counts 0→1→2, then FAIL with out_fail=1 and out_dcm_reset=1 held.
- **Restart from FAIL.** Pulse in_restart while in FAIL → next edge: out_fail=0, out_retry_count=0, new 4-cycle out_dcm_reset pulse.
- **Lock loss in RUN.** Drop in_dcm_locked while in RUN → 3 edges later: out_lock_lost single-cycle pulse, out_reset=2'b11, out_ready=0; DCM reset pulse reissued; out_retry_count unchanged.
- **Priority.** Assert in_restart on the same cycle lock_s falls in RUN → restart behaviour only: out_lock_lost stays 0. Assert in_reset_n=0 mid-RELEASE → all outputs at reset values on the next edge.
